sqr_meas: RTL and testbench

- ADC-side capture and measurement block, the receive counterpart of the square-wave DAC generator.
- Takes two 14-bit offset-binary ADC channels (AD_A, AD_B; midscale 8192) from the loopback/input path.
- Slices each channel with hysteresis and measures, once per A-period, the following: period, high time, peak-to-peak amplitude of A, and A→B rising-edge delay (phase).
- Results feed the control/readback logic that verifies generator settings.

---
 rtl/sqr_meas.sv | 241 ++++++++++++++++++++++++
 tb/tb_sqr_meas.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqr_meas.sv
// rtl/sqr_meas.sv - ADC square-wave capture: period, high time, A->B phase and A amplitude
//
// Build option: define SQR_MEAS_AVG_EN to report averages over groups of 4 windows.
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   rst        in   asynchronous active-high reset
//   en         in   measurement enable; low forces IDLE and discards the open window
//   AD_A/AD_B  in   14-bit offset-binary ADC samples
//   period     out  clk cycles between consecutive A rising edges
//   high_time  out  cycles the A slicer was high within the period
//   phase_dly  out  cycles from A rise to first B rise (0 when B was lost)
//   amp_pp     out  max(A) - min(A) over the period
//   b_lost     out  B slicer stayed without a rising edge for the whole period
//   valid      out  one-cycle pulse, coincident with updated results
//   timeout    out  one-cycle pulse, window/idle counter saturated
module sqr_meas #(
  parameter int CNT_W = 24,
  parameter int MID   = 8192,
  parameter int HYST  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [13:0]      AD_A,
  input  logic [13:0]      AD_B,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] phase_dly,
  output logic [13:0]      amp_pp,
  output logic             b_lost,
  output logic             valid,
  output logic             timeout
);

  localparam logic [13:0]      TH_HI   = 14'(MID + HYST);
  localparam logic [13:0]      TH_LO   = 14'(MID - HYST);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

  logic [13:0] s_a, s_b;
  logic        cmp_a, cmp_b, cmp_a_d, cmp_b_d;
  logic        rise_a, rise_b;

  state_t           state;
  logic [CNT_W-1:0] cnt, hi, ph;
  logic             bseen;
  logic [13:0]      mn, mx;

  // Closed-window results wait here one cycle so valid lines up with the outputs.
  logic             pend;
  logic [CNT_W-1:0] p_period, p_high, p_phase;
  logic [13:0]      p_amp;
  logic             p_blost;

  logic [13:0]      amp_w;
  logic [CNT_W-1:0] ph_w;
  logic             close_evt;
  logic             sat_evt;
  logic             grp_clr;

  // Input registers and hysteresis slicers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_a     <= '0;
      s_b     <= '0;
      cmp_a   <= 1'b0;
      cmp_b   <= 1'b0;
      cmp_a_d <= 1'b0;
      cmp_b_d <= 1'b0;
    end else begin
      s_a <= AD_A;
      s_b <= AD_B;
      if (s_a > TH_HI)      cmp_a <= 1'b1;
      else if (s_a < TH_LO) cmp_a <= 1'b0;
      if (s_b > TH_HI)      cmp_b <= 1'b1;
      else if (s_b < TH_LO) cmp_b <= 1'b0;
      cmp_a_d <= cmp_a;
      cmp_b_d <= cmp_b;
    end
  end

  assign rise_a = cmp_a & ~cmp_a_d;
  assign rise_b = cmp_b & ~cmp_b_d;

  assign amp_w     = mx - mn;
  assign ph_w      = bseen ? ph : '0;
  assign close_evt = en && (state == MEAS) && rise_a;
  // Saturation only matters when no A edge arrives to close/open a window.
  assign sat_evt   = en && (state != IDLE) && !rise_a && (cnt == CNT_MAX);
  assign grp_clr   = !en || sat_evt;

`ifdef SQR_MEAS_AVG_EN
  logic [CNT_W+1:0] acc_per, acc_hi, acc_ph;
  logic [CNT_W+1:0] sum_per, sum_hi, sum_ph;
  logic [13:0]      grp_amp, amp_max;
  logic             grp_bl;
  logic [1:0]       grp_n;

  assign sum_per = acc_per + {2'b00, cnt};
  assign sum_hi  = acc_hi + {2'b00, hi};
  assign sum_ph  = acc_ph + {2'b00, ph_w};
  assign amp_max = (amp_w > grp_amp) ? amp_w : grp_amp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_per <= '0;
      acc_hi  <= '0;
      acc_ph  <= '0;
      grp_amp <= '0;
      grp_bl  <= 1'b0;
      grp_n   <= 2'd0;
    end else if (grp_clr || (close_evt && grp_n == 2'd3)) begin
      acc_per <= '0;
      acc_hi  <= '0;
      acc_ph  <= '0;
      grp_amp <= '0;
      grp_bl  <= 1'b0;
      grp_n   <= 2'd0;
    end else if (close_evt) begin
      acc_per <= sum_per;
      acc_hi  <= sum_hi;
      acc_ph  <= sum_ph;
      grp_amp <= amp_max;
      grp_bl  <= grp_bl | ~bseen;
      grp_n   <= grp_n + 2'd1;
    end
  end
`endif

  // Measurement FSM and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hi        <= '0;
      ph        <= '0;
      bseen     <= 1'b0;
      mn        <= '0;
      mx        <= '0;
      pend      <= 1'b0;
      p_period  <= '0;
      p_high    <= '0;
      p_phase   <= '0;
      p_amp     <= '0;
      p_blost   <= 1'b0;
      period    <= '0;
      high_time <= '0;
      phase_dly <= '0;
      amp_pp    <= '0;
      b_lost    <= 1'b0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      pend    <= 1'b0;
      timeout <= 1'b0;
      valid   <= pend;
      if (pend) begin
        period    <= p_period;
        high_time <= p_high;
        phase_dly <= p_phase;
        amp_pp    <= p_amp;
        b_lost    <= p_blost;
      end

      if (!en) begin
        state <= IDLE;
        cnt   <= '0;
        hi    <= '0;
        ph    <= '0;
        bseen <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= ARM;

          ARM: begin
            if (rise_a) begin
              state <= MEAS;
              cnt   <= ONE;
              hi    <= CNT_W'(cmp_a);
              ph    <= '0;
              bseen <= rise_b;
              mn    <= s_a;
              mx    <= s_a;
            end else if (sat_evt) begin
              timeout <= 1'b1;
              cnt     <= '0;
            end else begin
              cnt <= cnt + ONE;
            end
          end

          MEAS: begin
            if (rise_a) begin
`ifdef SQR_MEAS_AVG_EN
              if (grp_n == 2'd3) begin
                pend     <= 1'b1;
                p_period <= sum_per[CNT_W+1:2];
                p_high   <= sum_hi[CNT_W+1:2];
                p_phase  <= sum_ph[CNT_W+1:2];
                p_amp    <= amp_max;
                p_blost  <= grp_bl | ~bseen;
              end
`else
              pend     <= 1'b1;
              p_period <= cnt;
              p_high   <= hi;
              p_phase  <= ph_w;
              p_amp    <= amp_w;
              p_blost  <= ~bseen;
`endif
              // The closing edge opens the next window; a coincident B edge belongs to it.
              cnt   <= ONE;
              hi    <= CNT_W'(cmp_a);
              ph    <= '0;
              bseen <= rise_b;
              mn    <= s_a;
              mx    <= s_a;
            end else if (sat_evt) begin
              timeout <= 1'b1;
              state   <= ARM;
              cnt     <= '0;
            end else begin
              cnt <= cnt + ONE;
              hi  <= hi + CNT_W'(cmp_a);
              if (!bseen) ph <= ph + ONE;
              if (rise_b) bseen <= 1'b1;
              if (s_a < mn) mn <= s_a;
              if (s_a > mx) mx <= s_a;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sqr_meas.sv
// tb/tb_sqr_meas.sv - directed scoreboard bench for sqr_meas
module tb_sqr_meas;

  logic        clk = 1'b0;
  logic        rst, en_m, en_t;
  logic [13:0] AD_A, AD_B;

  logic [23:0] period, high_time, phase_dly;
  logic [13:0] amp_pp;
  logic        b_lost, valid, timeout;

  logic [9:0]  t_period, t_high, t_phase;
  logic [13:0] t_amp;
  logic        t_blost, t_valid, t_timeout;

  always #5 clk = ~clk;

  sqr_meas dut (
    .clk(clk), .rst(rst), .en(en_m), .AD_A(AD_A), .AD_B(AD_B),
    .period(period), .high_time(high_time), .phase_dly(phase_dly),
    .amp_pp(amp_pp), .b_lost(b_lost), .valid(valid), .timeout(timeout)
  );

  sqr_meas #(.CNT_W(10)) dut10 (
    .clk(clk), .rst(rst), .en(en_t), .AD_A(AD_A), .AD_B(AD_B),
    .period(t_period), .high_time(t_high), .phase_dly(t_phase),
    .amp_pp(t_amp), .b_lost(t_blost), .valid(t_valid), .timeout(t_timeout)
  );

  typedef struct {
    int period;
    int high;
    int phase;
    int amp;
    int blost;
    int tick;
  } exp_t;

  exp_t sb[$];

  int cmp_n = 0;
  int err_n = 0;
  int tick_n = 0;

  // Waveform generator state
  int          t, per, high, last_per, bmode;
  int          bdly = 25;
  bit          noise, gen_on, seen_first;
  int          per_q[$];
  logic [13:0] idle_a;
  int          closes;
  int          mhigh, mphase, mblost;

  // Group model for the averaging build
  int g_n, g_per, g_hi, g_ph, g_amp, g_bl;

  // dut10 observation
  int to10_n, v10_n;
  int v10_period, v10_high, v10_phase, v10_amp, v10_blost;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_n++;
    assert (obs === exp) else begin
      err_n++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic grp_reset();
    g_n = 0; g_per = 0; g_hi = 0; g_ph = 0; g_amp = 0; g_bl = 0;
  endtask

  function automatic logic [13:0] wave(input int tt);
    if (noise) begin
      if (tt < 60) return 14'd12288;
      else if (tt < 100 || tt >= 140) return 14'(8142 + $urandom_range(0, 100));
      else return 14'd4096;
    end
    return (tt < high) ? 14'd12288 : 14'd4096;
  endfunction

  task automatic model_rise();
    exp_t w;
    if (!seen_first) begin
      seen_first = 1'b1;
    end else begin
      closes++;
      w.period = last_per;
      w.high   = mhigh;
      w.phase  = mphase;
      w.amp    = 8192;
      w.blost  = mblost;
      w.tick   = tick_n;
`ifdef SQR_MEAS_AVG_EN
      g_per += w.period;
      g_hi  += w.high;
      g_ph  += w.phase;
      if (w.amp > g_amp) g_amp = w.amp;
      g_bl  |= w.blost;
      g_n++;
      if (g_n == 4) begin
        w.period = g_per >> 2;
        w.high   = g_hi >> 2;
        w.phase  = g_ph >> 2;
        w.amp    = g_amp;
        w.blost  = g_bl;
        sb.push_back(w);
        grp_reset();
      end
`else
      sb.push_back(w);
`endif
    end
  endtask

  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    tick_n++;
    if (valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'(valid), 0);
      end else begin
        e = sb.pop_front();
        chk("period",    32'(period),    e.period);
        chk("high_time", 32'(high_time), e.high);
        chk("phase_dly", 32'(phase_dly), e.phase);
        chk("amp_pp",    32'(amp_pp),    e.amp);
        chk("b_lost",    32'(b_lost),    e.blost);
        chk("latency",   tick_n - e.tick, 4);
      end
    end
    if (timeout) chk("main_timeout", 32'(timeout), 0);
    if (t_timeout) to10_n++;
    if (t_valid) begin
      v10_n++;
      v10_period = int'(t_period);
      v10_high   = int'(t_high);
      v10_phase  = int'(t_phase);
      v10_amp    = int'(t_amp);
      v10_blost  = int'(t_blost);
    end
  endtask

  task automatic tick();
    logic [13:0] a, b;
    if (gen_on) begin
      a = wave(t);
      case (bmode)
        0:       b = wave((t + per - bdly) % per);
        1:       b = 14'd4096;
        default: b = a;
      endcase
    end else begin
      a = idle_a;
      b = 14'd4096;
    end
    AD_A = a;
    AD_B = b;
    if (gen_on && t == 0 && en_m && !rst) model_rise();
    cyc();
    if (gen_on) begin
      t++;
      if (t >= per) begin
        last_per = per;
        t = 0;
        if (per_q.size() > 0) per = per_q.pop_front();
      end
    end
  endtask

  task automatic seg_start(input int p, input int h, input int bm, input bit nz);
    per = p; high = h; bmode = bm; noise = nz;
    t = p - 20; last_per = p; seen_first = 1'b0; closes = 0;
    grp_reset();
    mhigh  = nz ? 100 : h;
    mphase = (bm == 0) ? bdly : 0;
    mblost = (bm == 1) ? 1 : 0;
    gen_on = 1'b1; en_m = 1'b1; en_t = 1'b1;
  endtask

  task automatic run_until(input int nwin, input int stop_t);
    int n;
    n = 0;
    while (!(closes >= nwin && t == stop_t) && n < 5000) begin
      tick();
      n++;
    end
  endtask

  task automatic seg_end();
    en_m = 1'b0; en_t = 1'b0; gen_on = 1'b0; idle_a = 14'd4096;
    repeat (8) tick();
    chk("drain", sb.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_period"}, 32'(period),    0);
    chk({tag, "_high"},   32'(high_time), 0);
    chk({tag, "_phase"},  32'(phase_dly), 0);
    chk({tag, "_amp"},    32'(amp_pp),    0);
    chk({tag, "_blost"},  32'(b_lost),    0);
    chk({tag, "_valid"},  32'(valid),     0);
    chk({tag, "_tmo"},    32'(timeout),   0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired compared=%0d", cmp_n);
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; en_m = 1'b0; en_t = 1'b0; gen_on = 1'b0; idle_a = 14'd4096;
    AD_A = 14'd4096; AD_B = 14'd4096;
    repeat (3) tick();
    chk_zero("reset");
    rst = 1'b0;
    repeat (3) tick();

    // Clean square wave, B delayed 25
    seg_start(100, 30, 0, 1'b0); run_until(4, 10); seg_end();
    // Noise inside hysteresis between clean edges, period 200
    seg_start(200, 30, 0, 1'b1); run_until(4, 10); seg_end();
    // B stuck low
    seg_start(100, 30, 1, 1'b0); run_until(4, 10); seg_end();
    // B identical to A
    seg_start(100, 30, 2, 1'b0); run_until(4, 10); seg_end();

    // Timeout on the 10-bit instance: A held high after one rise
    en_m = 1'b0; en_t = 1'b1; gen_on = 1'b0; idle_a = 14'd4096;
    repeat (20) tick();
    to10_n = 0; v10_n = 0;
    idle_a = 14'd12288;
    n = 0;
    while (to10_n == 0 && n < 1200) begin
      tick();
      n++;
    end
    chk("t10_timeout_seen",  to10_n, 1);
    chk("t10_timeout_delay", n, 1026);
    chk("t10_no_valid",      v10_n, 0);
    chk("t10_hold_period",   32'(t_period), 100);
    chk("t10_hold_high",     32'(t_high),   30);
    chk("t10_hold_phase",    32'(t_phase),  0);
    chk("t10_hold_amp",      32'(t_amp),    8192);
    chk("t10_hold_blost",    32'(t_blost),  0);
    tick();
    chk("t10_pulse_width",   32'(t_timeout), 0);
    idle_a = 14'd4096;
    repeat (50) tick();
    // Back in ARM: a fresh pair of edges must measure again
    per = 100; high = 30; bmode = 1; noise = 1'b0; t = 80; last_per = 100;
    gen_on = 1'b1; v10_n = 0; n = 0;
    while (v10_n == 0 && n < 800) begin
      tick();
      n++;
    end
    chk("t10_rearm_valid",  v10_n,      1);
    chk("t10_rearm_period", v10_period, 100);
    chk("t10_rearm_high",   v10_high,   30);
    chk("t10_rearm_phase",  v10_phase,  0);
    chk("t10_rearm_amp",    v10_amp,    8192);
    chk("t10_rearm_blost",  v10_blost,  1);
    gen_on = 1'b0; en_t = 1'b0;
    repeat (8) tick();

    // Alternating periods 100/102
    per_q = '{100, 102, 100, 102};
    seg_start(100, 30, 0, 1'b0); run_until(4, 10); seg_end();

    // en drop mid-window, then rst mid-window, then resume
    seg_start(100, 30, 0, 1'b0);
    run_until(4, 50);
    en_m = 1'b0; en_t = 1'b0; seen_first = 1'b0; grp_reset();
    repeat (10) tick();
    en_m = 1'b1; en_t = 1'b1; closes = 0;
    run_until(4, 50);
    rst = 1'b1; seen_first = 1'b0; grp_reset();
    tick();
    tick();
    chk_zero("midrst");
    rst = 1'b0; closes = 0;
    run_until(4, 10);
    seg_end();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
